// File: rtl/event_median_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : event_median_sequencer
// Brief    : Clear / accumulate / 3x3 binary-median scan sequencer that owns
//            the single-port event image memory.
// Revision : 1.0 - initial release
// ============================================================================
module event_median_sequencer #(
  parameter int IMWIDTH  = 240,
  parameter int IMHEIGHT = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       evt_valid,
  output logic       evt_ready,
  input  logic [7:0] evt_x,
  input  logic [7:0] evt_y,
  input  logic       frame_end,
  output logic [7:0] mem_xAddr,
  output logic [7:0] mem_yAddr,
  output logic       mem_eventIn,
  output logic       mem_write,
  input  logic       mem_eventOut,
  output logic       pix_valid,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  output logic       pix_data,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] c_XMAX   = 8'(IMWIDTH - 1);
  localparam logic [7:0] c_YMAX   = 8'(IMHEIGHT - 1);
  localparam logic [8:0] c_WIDTH  = 9'(IMWIDTH);
  localparam logic [8:0] c_HEIGHT = 9'(IMHEIGHT);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_curX, r_curY;
  logic [1:0] r_kx, r_ky;
  logic       r_issueDone;
  logic       r_s1Valid, r_s1Mask, r_s1First, r_s1Last, r_s1Final;
  logic [7:0] r_s1X, r_s1Y;
  logic       r_s2Valid, r_s2Mask, r_s2First, r_s2Last, r_s2Final;
  logic [7:0] r_s2X, r_s2Y;
  logic [3:0] r_count;
  logic       r_doneP;

  logic       w_hs, w_inRange, w_lastPix, w_xIn, w_yIn, w_add;
  logic [7:0] w_nX, w_nY, w_nextX, w_nextY;
  logic [3:0] w_sum;

  always_comb begin
    w_hs      = evt_valid && evt_ready;
    w_inRange = ({1'b0, evt_x} < c_WIDTH) && ({1'b0, evt_y} < c_HEIGHT);
    w_lastPix = (r_curX == c_XMAX) && (r_curY == c_YMAX);
    w_nextX   = (r_curX == c_XMAX) ? 8'd0 : r_curX + 8'd1;
    w_nextY   = (r_curX == c_XMAX) ? ((r_curY == c_YMAX) ? 8'd0 : r_curY + 8'd1) : r_curY;
    w_xIn     = !((r_kx == 2'd0 && r_curX == 8'd0) || (r_kx == 2'd2 && r_curX == c_XMAX));
    w_yIn     = !((r_ky == 2'd0 && r_curY == 8'd0) || (r_ky == 2'd2 && r_curY == c_YMAX));
    w_nX      = (r_kx == 2'd0) ? r_curX - 8'd1 : (r_kx == 2'd2) ? r_curX + 8'd1 : r_curX;
    w_nY      = (r_ky == 2'd0) ? r_curY - 8'd1 : (r_ky == 2'd2) ? r_curY + 8'd1 : r_curY;
    // stage 2 lines up with the read data of the read issued two edges back
    w_add     = r_s2Mask & mem_eventOut;
    w_sum     = (r_s2First ? 4'd0 : r_count) + {3'b000, w_add};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CLEAR;
      r_curX      <= 8'd0;
      r_curY      <= 8'd0;
      r_kx        <= 2'd0;
      r_ky        <= 2'd0;
      r_issueDone <= 1'b0;
      r_s1Valid   <= 1'b0;
      r_s1Mask    <= 1'b0;
      r_s1First   <= 1'b0;
      r_s1Last    <= 1'b0;
      r_s1Final   <= 1'b0;
      r_s1X       <= 8'd0;
      r_s1Y       <= 8'd0;
      r_s2Valid   <= 1'b0;
      r_s2Mask    <= 1'b0;
      r_s2First   <= 1'b0;
      r_s2Last    <= 1'b0;
      r_s2Final   <= 1'b0;
      r_s2X       <= 8'd0;
      r_s2Y       <= 8'd0;
      r_count     <= 4'd0;
      r_doneP     <= 1'b0;
      evt_ready   <= 1'b0;
      mem_xAddr   <= 8'd0;
      mem_yAddr   <= 8'd0;
      mem_eventIn <= 1'b0;
      mem_write   <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= 8'd0;
      pix_y       <= 8'd0;
      pix_data    <= 1'b0;
      busy        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      r_s1Valid  <= 1'b0;
      mem_write  <= 1'b0;
      r_doneP    <= 1'b0;
      frame_done <= r_doneP;
      case (r_state)
        CLEAR: begin
          mem_write   <= 1'b1;
          mem_eventIn <= 1'b0;
          mem_xAddr   <= r_curX;
          mem_yAddr   <= r_curY;
          r_curX      <= w_nextX;
          r_curY      <= w_nextY;
          if (w_lastPix) r_state <= ACCUM;
        end
        ACCUM: begin
          evt_ready <= !frame_end;
          busy      <= frame_end;
          if (w_hs && w_inRange) begin
            mem_write   <= 1'b1;
            mem_eventIn <= 1'b1;
            mem_xAddr   <= evt_x;
            mem_yAddr   <= evt_y;
          end
          if (frame_end) begin
            r_state     <= SCAN;
            r_issueDone <= 1'b0;
            r_kx        <= 2'd0;
            r_ky        <= 2'd0;
          end
        end
        SCAN: begin
          if (!r_issueDone) begin
            // out-of-frame neighbours re-read the centre pixel and are masked
            mem_xAddr   <= (w_xIn && w_yIn) ? w_nX : r_curX;
            mem_yAddr   <= (w_xIn && w_yIn) ? w_nY : r_curY;
            mem_eventIn <= 1'b0;
            r_s1Valid   <= 1'b1;
            r_s1Mask    <= w_xIn && w_yIn;
            r_s1First   <= (r_kx == 2'd0) && (r_ky == 2'd0);
            r_s1Last    <= (r_kx == 2'd2) && (r_ky == 2'd2);
            r_s1Final   <= (r_kx == 2'd2) && (r_ky == 2'd2) && w_lastPix;
            r_s1X       <= r_curX;
            r_s1Y       <= r_curY;
            if (r_kx != 2'd2) begin
              r_kx <= r_kx + 2'd1;
            end else begin
              r_kx <= 2'd0;
              if (r_ky != 2'd2) begin
                r_ky <= r_ky + 2'd1;
              end else begin
                r_ky   <= 2'd0;
                r_curX <= w_nextX;
                r_curY <= w_nextY;
                if (w_lastPix) r_issueDone <= 1'b1;
              end
            end
          end
        end
        default: r_state <= CLEAR;
      endcase

      r_s2Valid <= r_s1Valid;
      r_s2Mask  <= r_s1Mask;
      r_s2First <= r_s1First;
      r_s2Last  <= r_s1Last;
      r_s2Final <= r_s1Final;
      r_s2X     <= r_s1X;
      r_s2Y     <= r_s1Y;
      pix_valid <= 1'b0;
      if (r_s2Valid) begin
        r_count <= w_sum;
        if (r_s2Last) begin
          pix_valid <= 1'b1;
          pix_x     <= r_s2X;
          pix_y     <= r_s2Y;
          pix_data  <= (w_sum >= 4'd5);
        end
        if (r_s2Final) begin
          r_doneP <= 1'b1;
          r_state <= CLEAR;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_event_median_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_median_sequencer
// Brief    : Directed bench with a frame-level reference model of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_event_median_sequencer;

  localparam int W = 16;
  localparam int H = 12;
  localparam int N = W * H;
  localparam int PH_CLEAR = 0;
  localparam int PH_ACCUM = 1;
  localparam int PH_SCAN  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       evt_valid = 1'b0;
  logic       frame_end = 1'b0;
  logic [7:0] evt_x = 8'd0;
  logic [7:0] evt_y = 8'd0;
  logic       evt_ready;
  logic [7:0] mem_xAddr, mem_yAddr;
  logic       mem_eventIn, mem_write;
  logic       mem_eventOut = 1'b0;
  logic       pix_valid, pix_data, busy, frame_done;
  logic [7:0] pix_x, pix_y;

  always #5 clk = ~clk;

  event_median_sequencer #(.IMWIDTH(W), .IMHEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_x(evt_x), .evt_y(evt_y),
    .frame_end(frame_end),
    .mem_xAddr(mem_xAddr), .mem_yAddr(mem_yAddr), .mem_eventIn(mem_eventIn),
    .mem_write(mem_write), .mem_eventOut(mem_eventOut),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .busy(busy), .frame_done(frame_done)
  );

  // Synchronous single-port memory, pre-filled with ones so the clear matters.
  bit memArr [0:255][0:255];
  initial foreach (memArr[i, j]) memArr[i][j] = 1'b1;
  always @(posedge clk) begin
    if (mem_write) memArr[mem_xAddr][mem_yAddr] <= mem_eventIn;
    mem_eventOut <= memArr[mem_xAddr][mem_yAddr];
  end

  int nCmp = 0, nFail = 0;
  int nPix = 0, nOnes = 0, nFd = 0, nAccWr = 0, nClrWr = 0;
  bit img [0:W-1][0:H-1];
  bit pixOut [0:W-1][0:H-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit majority(input int x, input int y);
    int cnt = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
          if (img[x + dx][y + dy]) cnt++;
    return cnt >= 5;
  endfunction

  // Reference model: phase + cycle-in-phase, expectations from arithmetic.
  int ph = PH_CLEAR, c = 0;
  bit fdExp = 0, accWr = 0;
  int accX = 0, accY = 0;
  int p, k, px, py, nx, ny;
  bit eRdy, eBusy, eWr, eEvIn, eAddrChk, ePv, ePd, eFd;
  int eX, eY, ePx, ePy;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_evt_ready", evt_ready, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_eventIn", mem_eventIn, 0);
      chk("rst_mem_xAddr", mem_xAddr, 0);
      chk("rst_mem_yAddr", mem_yAddr, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_x", pix_x, 0);
      chk("rst_pix_y", pix_y, 0);
      chk("rst_pix_data", pix_data, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 1);
      ph = PH_CLEAR; c = 0; fdExp = 0; accWr = 0;
      foreach (img[i, j]) img[i][j] = 1'b0;
    end else begin
      eRdy = 0; eBusy = 1; eWr = 0; eEvIn = 0; eAddrChk = 0; eX = 0; eY = 0;
      ePv = 0; ePx = 0; ePy = 0; ePd = 0; eFd = 0;
      case (ph)
        PH_CLEAR: begin
          eWr = 1; eAddrChk = 1; eX = c % W; eY = c / W; eFd = fdExp && (c == 0);
        end
        PH_ACCUM: begin
          eRdy = 1; eBusy = 0; eWr = accWr; eEvIn = 1; eAddrChk = accWr; eX = accX; eY = accY;
        end
        default: begin
          if (c < 0) begin
            eWr = accWr; eEvIn = 1; eAddrChk = accWr; eX = accX; eY = accY;
          end else if (c < 9 * N) begin
            p = c / 9; k = c % 9; px = p % W; py = p / W;
            nx = px + (k % 3) - 1; ny = py + (k / 3) - 1;
            if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin nx = px; ny = py; end
            eAddrChk = 1; eX = nx; eY = ny;
          end
          if (c >= 10 && (c - 10) % 9 == 0 && (c - 10) / 9 < N) begin
            p = (c - 10) / 9; ePv = 1; ePx = p % W; ePy = p / W; ePd = majority(ePx, ePy);
          end
        end
      endcase
      chk("evt_ready", evt_ready, eRdy);
      chk("busy", busy, eBusy);
      chk("mem_write", mem_write, eWr);
      if (eAddrChk) begin
        chk("mem_xAddr", mem_xAddr, eX);
        chk("mem_yAddr", mem_yAddr, eY);
      end
      if (eWr) chk("mem_eventIn", mem_eventIn, eEvIn);
      chk("pix_valid", pix_valid, ePv);
      if (ePv) begin
        chk("pix_x", pix_x, ePx);
        chk("pix_y", pix_y, ePy);
        chk("pix_data", pix_data, ePd);
      end
      chk("frame_done", frame_done, eFd);

      if (pix_valid === 1'b1 && int'(pix_x) < W && int'(pix_y) < H) begin
        nPix++;
        pixOut[int'(pix_x)][int'(pix_y)] = pix_data;
        if (pix_data === 1'b1) nOnes++;
      end
      if (frame_done === 1'b1) nFd++;
      if (mem_write === 1'b1 && mem_eventIn === 1'b1) nAccWr++;
      if (mem_write === 1'b1 && mem_eventIn === 1'b0) nClrWr++;

      case (ph)
        PH_CLEAR: begin
          c++; fdExp = 0;
          if (c == N) begin ph = PH_ACCUM; c = 0; accWr = 0; end
        end
        PH_ACCUM: begin
          accWr = 0;
          if (evt_valid) begin
            if (int'(evt_x) < W && int'(evt_y) < H) begin
              accWr = 1; accX = evt_x; accY = evt_y; img[int'(evt_x)][int'(evt_y)] = 1'b1;
            end
          end
          if (frame_end) begin ph = PH_SCAN; c = -1; end
        end
        default: begin
          c++;
          if (c == 9 * N + 2) begin
            ph = PH_CLEAR; c = 0; fdExp = 1;
            foreach (img[i, j]) img[i][j] = 1'b0;
          end
        end
      endcase
    end
  end

  task automatic send_evt(input int x, input int y, input bit fe);
    evt_valid = 1'b1; evt_x = 8'(x); evt_y = 8'(y); frame_end = fe;
    @(posedge clk); #1;
    evt_valid = 1'b0; frame_end = 1'b0;
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (evt_ready !== 1'b1 && n < 4000) begin @(posedge clk); #1; n++; end
    if (evt_ready !== 1'b1) chk("evt_ready_timeout", 0, 1);
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    while (frame_done !== 1'b1 && n < 4000) begin @(posedge clk); #1; n++; end
    if (frame_done !== 1'b1) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic clr_counts();
    nPix = 0; nOnes = 0; nFd = 0; nAccWr = 0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    wait_ready(n);
    chk("clear_len_after_reset", n, 193);
    chk("clear_write_count", nClrWr, 192);

    // single isolated event: every median is 0
    clr_counts();
    send_evt(10, 10, 1'b0);
    pulse_fe();
    wait_fd(n);
    wait_ready(n);
    chk("clear_len_after_scan", n, 192);
    chk("single_pix_count", nPix, 192);
    chk("single_ones", nOnes, 0);
    chk("single_frame_done", nFd, 1);

    // 3x3 block, last event together with frame_end
    clr_counts();
    for (int y = 5; y <= 7; y++)
      for (int x = 5; x <= 7; x++)
        send_evt(x, y, (x == 7 && y == 7));
    wait_fd(n);
    wait_ready(n);
    chk("block_ones", nOnes, 5);
    chk("block_6_5", pixOut[6][5], 1);
    chk("block_5_6", pixOut[5][6], 1);
    chk("block_6_6", pixOut[6][6], 1);
    chk("block_7_6", pixOut[7][6], 1);
    chk("block_6_7", pixOut[6][7], 1);
    chk("block_5_5", pixOut[5][5], 0);
    chk("block_7_7", pixOut[7][7], 0);

    // corner events, out-of-range drops, frame_end misuse in SCAN and CLEAR
    clr_counts();
    send_evt(0, 0, 1'b0);
    send_evt(1, 0, 1'b0);
    send_evt(0, 1, 1'b0);
    send_evt(1, 1, 1'b0);
    send_evt(16, 0, 1'b0);
    send_evt(240, 0, 1'b0);
    send_evt(3, 200, 1'b0);
    pulse_fe();
    repeat (50) begin @(posedge clk); #1; end
    pulse_fe();
    wait_fd(n);
    repeat (5) begin @(posedge clk); #1; end
    pulse_fe();
    wait_ready(n);
    chk("border_writes", nAccWr, 4);
    chk("border_0_0", pixOut[0][0], 0);
    chk("border_ones", nOnes, 0);
    chk("border_pix_count", nPix, 192);
    chk("border_frame_done", nFd, 1);

    clr_counts();
    send_evt(0, 0, 1'b0);
    send_evt(1, 0, 1'b0);
    send_evt(2, 0, 1'b0);
    send_evt(0, 1, 1'b0);
    send_evt(1, 1, 1'b0);
    send_evt(2, 1, 1'b1);
    wait_fd(n);
    wait_ready(n);
    chk("border2_1_0", pixOut[1][0], 1);
    chk("border2_0_0", pixOut[0][0], 0);
    chk("border2_ones", nOnes, 2);

    // reset in the middle of a scan
    send_evt(10, 5, 1'b0);
    pulse_fe();
    n = 0;
    while (!(pix_valid === 1'b1 && pix_x == 8'd10 && pix_y == 8'd5) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3000) chk("mid_scan_pixel_timeout", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    clr_counts();
    wait_ready(n);
    chk("clear_len_after_midreset", n, 193);
    chk("no_pix_after_reset", nPix, 0);

    // block in the bottom-right corner
    clr_counts();
    for (int y = 9; y <= 11; y++)
      for (int x = 13; x <= 15; x++)
        send_evt(x, y, (x == 15 && y == 11));
    wait_fd(n);
    wait_ready(n);
    chk("corner_ones", nOnes, 5);
    chk("corner_14_10", pixOut[14][10], 1);
    chk("corner_15_11", pixOut[15][11], 0);
    chk("corner_pix_count", nPix, 192);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/event_median_sequencer.md
# event_median_sequencer

Sequencer that owns the single-port 240×180 binary event image memory in the median filter datapath. It runs three phases in a fixed loop:
- clear the memory;
- accumulate incoming address events as 1-bits;
- raster-scan the frame, reading each pixel's 3×3 neighbourhood and emitting the binary median (majority of 9, zero-padded at borders).

It sits between the event input stream and the downstream filtered-pixel consumer, and is the only master of the memory port.

## Interface
Parameters:
- IMWIDTH, 240, image width in pixels
- IMHEIGHT, 180, image height in pixels

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  sole clock; all logic on rising edge
  - rst  in  1  reset
- Event input:
  - evt_valid  in  1  event present
  - evt_ready  out  1  event accepted when evt_valid && evt_ready
  - evt_x  in  8  event column
  - evt_y  in  8  event row
  - frame_end  in  1  single-cycle pulse; ends accumulation
- Memory port:
  - mem_xAddr  out  8  memory column address
  - mem_yAddr  out  8  memory row address
  - mem_eventIn  out  1  write data
  - mem_write  out  1  1 = write, 0 = read
  - mem_eventOut  in  1  read data; valid the cycle after the address is presented
- Filtered-pixel output:
  - pix_valid  out  1  filtered pixel strobe; no backpressure
  - pix_x  out  8  filtered pixel column
  - pix_y  out  8  filtered pixel row
  - pix_data  out  1  median result
- Status:
  - busy  out  1  high in CLEAR and SCAN
  - frame_done  out  1  one-cycle pulse after the last pixel of a scan

## Operation
- States: CLEAR → ACCUM → SCAN → CLEAR. Reset enters CLEAR.
- CLEAR
  - mem_write=1, mem_eventIn=0.
  - Address walks raster order (x fastest), (0,0) to (239,179), one location per cycle: 43200 cycles.
  - Then go to ACCUM.
- ACCUM
  - evt_ready=1.
  - On handshake with evt_x<240 and evt_y<180: write 1 at (evt_x,evt_y).
  - Out-of-range events are accepted and dropped, with no write.
  - frame_end moves to SCAN. An event accepted in the same cycle is still written.
- SCAN
  - For each pixel (px,py) in raster order, issue 9 neighbour reads, k=0..8: dy=-1..1 outer, dx=-1..1 inner.
  - A neighbour outside 0..239 / 0..179 still consumes its slot. For that slot: address held at (px,py), read issued, tally masked to 0.
  - 4-bit count of ones.
  - Result: pix_data = (count ≥ 5).
  - After pixel (239,179): pulse frame_done, go to CLEAR.
- Outside ACCUM:
  - evt_ready=0.
  - frame_end is ignored, not latched.
- mem_write=1 only in CLEAR and on ACCUM event writes. The memory is never driven with x≥240 or y≥180.
- All outputs are registered.

## Timing
- Reset values:
  - evt_ready=0, mem_write=0, mem_eventIn=0, mem_xAddr=0, mem_yAddr=0.
  - pix_valid=0, pix_x=0, pix_y=0, pix_data=0, frame_done=0.
  - busy=1.
  - All counters 0.
- Reset mid-operation: abort immediately, discard the partial pixel, restart CLEAR from (0,0).
- After rst deasserts: first CLEAR write in cycle 1; evt_ready rises the cycle after the final clear write.
- Read pipeline:
  - A read for neighbour k issued in cycle t+k is tallied from mem_eventOut in cycle t+k+1.
  - Reads of the next pixel start at t+9, overlapped with the last tally.
  - pix_valid is high for one cycle at t+10, with pix_x/pix_y/pix_data of pixel t.
  - Throughput: one pixel per 9 cycles; full scan = 388800 cycles of issue plus 2 drain cycles.
- frame_done is asserted in the cycle after the last pix_valid. CLEAR begins the same cycle.
- First SCAN read is the cycle after the frame_end handshake, so the last event write is already committed.

## Test plan
- Reset, then idle:
  - mem_write high with mem_eventIn=0 for exactly 43200 cycles, addresses (0,0)..(239,179).
  - Then evt_ready=1.
- Single event at (10,10), then frame_end:
  - 43200 pix_valid pulses in raster order, all pix_data=0.
  - frame_done once.
  - CLEAR restarts.
- Events filling (5..7,5..7), then frame_end:
  - pix_data=1 only at (6,5), (5,6), (6,6), (7,6), (6,7) (counts 6 and 9).
  - Corners (5,5),(7,7) give count 4 → 0.
  - All other pixels 0.
- Border padding: events at (0,0),(1,0),(0,1),(1,1), then frame_end:
  - (0,0) has count 4 → 0.
  - With (2,0),(2,1) added, pixel (1,0) has count 6 → 1.
- Out-of-range and misuse:
  - Event (240,0) is accepted with no mem_write pulse.
  - frame_end pulsed during SCAN and CLEAR changes nothing.
  - evt_ready stays 0 in both.
- Reset asserted mid-SCAN at pixel (100,50):
  - All outputs take their reset values immediately.
  - CLEAR restarts at (0,0).
  - No further pix_valid until a new frame_end.
